// File: rtl/wishbone_slave_mem.sv
// wishbone_slave_mem: Wishbone classic-cycle slave backed by a word-addressed
// memory. It supports byte-lane writes, 0-15 programmable wait states, error
// termination for misaligned or out-of-window addresses and an access counter.
// Optional retry injection is compiled in with the macro WB_SLAVE_RETRY_EN.
//
// Handshake: the master holds cyc & stb (with adr/we/sel/din stable) as its
// request. The slave accepts it on the first rising edge where it is IDLE and
// cyc & stb are high. It then ends the access with exactly one of ack/err/rty,
// high for one cycle, W edges after acceptance, where W is the wait_states
// value latched at acceptance. If cyc drops while the slave waits, the access
// is abandoned silently.
module wishbone_slave_mem #(
  parameter int          ADDR_BITS = 6,
  parameter logic [31:0] BASE      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        cyc,
  input  logic        stb,
  input  logic [3:0]  sel,
  input  logic        we,
  output logic        ack,
  output logic        err,
  output logic        rty,
  input  logic [3:0]  wait_states,
  input  logic [3:0]  rty_every,
  output logic [15:0] acc_cnt,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         DEPTH  = 1 << ADDR_BITS;

  logic [1:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] dout_q, dout_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rty_q, rty_d;
  logic [15:0] acc_q, acc_d;

  logic [31:0] mem_q [DEPTH];

  // The request being terminated: live bus signals when responding straight
  // from IDLE (zero wait states), otherwise the values latched at acceptance.
  logic                 in_idle;
  logic [31:0]          req_adr;
  logic [31:0]          req_din;
  logic [3:0]           req_sel;
  logic                 req_we;
  logic [32:0]          diff;
  logic                 addr_bad;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 resp_enter;
  logic                 retry_hit;
  logic                 mem_we;

  assign in_idle = (state_q == S_IDLE);
  assign req_adr = in_idle ? adr : adr_q;
  assign req_din = in_idle ? din : din_q;
  assign req_sel = in_idle ? sel : sel_q;
  assign req_we  = in_idle ? we  : we_q;

  // The borrow bit of the 33-bit subtraction flags addresses below BASE.
  // BASE is word aligned, so the low offset bits equal the low address bits.
  assign diff     = {1'b0, req_adr} - {1'b0, BASE};
  assign addr_bad = diff[32] | (diff[1:0] != 2'b00) | (|diff[31:ADDR_BITS+2]);
  assign word_idx = diff[ADDR_BITS+1:2];

`ifdef WB_SLAVE_RETRY_EN
  logic [3:0] rcnt_q, rcnt_d, rcnt_inc;

  assign rcnt_inc  = rcnt_q + 4'd1;
  assign retry_hit = (rty_every != 4'd0) && (rcnt_inc == rty_every);

  // Count requests that were not errored; restart after every injected retry.
  always_comb begin
    rcnt_d = rcnt_q;
    if (resp_enter && !addr_bad) begin
      rcnt_d = retry_hit ? 4'd0 : rcnt_inc;
    end
  end

  // Retry counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rcnt_q <= 4'd0;
    else      rcnt_q <= rcnt_d;
  end
`else
  logic unused_rty_every;
  assign unused_rty_every = ^rty_every;
  assign retry_hit        = 1'b0;
`endif

  // Memory is written only for ack-terminated writes, never while in reset.
  assign mem_we = rst & resp_enter & ~addr_bad & ~retry_hit & req_we;

  // Next-state logic: accept, count down wait states, terminate, return to IDLE.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    din_d      = din_q;
    sel_d      = sel_q;
    we_d       = we_q;
    wcnt_d     = wcnt_q;
    dout_d     = dout_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    acc_d      = acc_q;
    resp_enter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cyc && stb) begin
          adr_d  = adr;
          din_d  = din;
          sel_d  = sel;
          we_d   = we;
          wcnt_d = wait_states;
          if (wait_states == 4'd0) resp_enter = 1'b1;
          else                     state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cyc)                state_d    = S_IDLE;
        else if (wcnt_q == 4'd1) resp_enter = 1'b1;
        else                     wcnt_d     = wcnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (resp_enter) begin
      state_d = S_RESP;
      if (addr_bad) begin
        err_d = 1'b1;
      end else if (retry_hit) begin
        rty_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        acc_d = acc_q + 16'd1;
        if (!req_we) dout_d = mem_q[word_idx];
      end
    end
  end

  // Control and response registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      adr_q   <= 32'd0;
      din_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      wcnt_q  <= 4'd0;
      dout_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      acc_q   <= acc_d;
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_sel[i]) mem_q[word_idx][8*i +: 8] <= req_din[8*i +: 8];
      end
    end
  end

  assign dout      = dout_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rty       = rty_q;
  assign acc_cnt   = acc_q;
  assign state_dbg = state_q;

endmodule
